tb_test_status_ctrl: RTL and testbench
======================================

# tb_test_status_ctrl

Memory-mapped end-of-test controller for the Verilator core bench, sitting on the data bus beside the RAM and stdout peripheral. It generalises the single pass/fail pair into per-hart exit registers, a global pass/fail/timeout state machine, a watchdog and a 64-bit cycle counter readable by firmware. The bench top samples its sticky outputs to print the verdict and call $finish.

## Interface
- NUM_HARTS, 1: number of exit channels (1..16).
- ADDR_WIDTH, 8: width of the word-offset-relevant address bits decoded (byte address, low bits only).
- TIMEOUT_CYCLES, 1000000: watchdog limit in cycles; 0 disables the watchdog.
- clk_i  in  1  clock; everything is on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- data_req_i  in  1  bus request.
- data_we_i  in  1  1 = write, 0 = read.
- data_addr_i  in  ADDR_WIDTH  byte address offset from peripheral base.
- data_wdata_i  in  32  write data.
- data_gnt_o  out  1  grant, combinational, equal to data_req_i.
- data_rvalid_o  out  1  response valid, one cycle after every granted request (read or write).
- data_rdata_o  out  32  read data, valid with data_rvalid_o, 0 otherwise.
- tests_passed_o  out  1  sticky: all harts exited with code 0.
- tests_failed_o  out  1  sticky: a hart exited non-zero or watchdog expired.
- timeout_o  out  1  sticky: watchdog expired.
- exit_code_o  out  31  exit code of the failing hart; 0 otherwise.
- fail_hart_o  out  4  index of the failing hart; 0 otherwise.

## Operation
- Register map (word aligned, data_addr_i[1:0] ignored):
  - 0x00 + 4*h, EXIT[h], W: h < NUM_HARTS.
  - 0x40 CYCLE_LO, R: latches CYCLE_HI snapshot.
  - 0x44 CYCLE_HI, R: returns snapshot.
  - 0x48 DONE_MASK, R: bit h = hart h exited.
  - 0x4C WDOG_KICK, W: any data clears watchdog.
- EXIT write:
  - wdata[0]=0: ignored.
  - wdata[0]=1: marks hart done with code = wdata[31:1]; only the first done write per hart counts, later ones are ignored.
- Unmapped or out-of-range accesses: writes have no effect; reads return 0; a response is still given.
- State machine (state reg, reset to RUN):
  - RUN -> FAIL on an EXIT done write with non-zero code; latches exit_code_o and fail_hart_o.
  - RUN -> PASS when the done mask becomes all-ones and every code was 0.
  - RUN -> TIMEOUT when the watchdog counter reaches TIMEOUT_CYCLES (if non-zero).
  - PASS, FAIL and TIMEOUT are terminal until rst_i; no further transitions, and EXIT writes are ignored.
- Outputs decode from the registered state:
  - tests_passed_o = PASS.
  - tests_failed_o = FAIL or TIMEOUT.
  - timeout_o = TIMEOUT.
- Watchdog: counts +1 per cycle in RUN; cleared on a WDOG_KICK or accepted EXIT write, in the same edge as the write; frozen in terminal states.
- Cycle counter: 64 bits, increments every cycle in RUN, wraps modulo 2^64, frozen in terminal states.
- Reset mid-operation clears counters, done mask, snapshot, codes and state on the next edge regardless of bus activity; a request in that cycle is still given a response in the following cycle.

## Timing
- Reset values:
  - all outputs 0 except data_gnt_o (= data_req_i).
  - state RUN; counters 0.
- Request accepted at edge N (req high before N):
  - data_rvalid_o is high in cycle N..N+1.
  - read data reflects register values before edge N.
- EXIT write accepted at edge N: done bit and any state change are visible after edge N; tests_passed_o/tests_failed_o are high from cycle N onward.
- Watchdog: with no kicks after reset deassertion at edge 0, timeout_o rises after edge TIMEOUT_CYCLES.
- CYCLE_LO read at edge N returns the count before edge N; the snapshot of the upper word is taken at that same edge.
- Back-to-back requests every cycle are supported; no stalls.

## Test plan
- NUM_HARTS=1: write 0x1 to 0x00 -> tests_passed_o=1 next cycle, tests_failed_o=0, exit_code_o=0, cycle counter frozen.
- NUM_HARTS=4: harts 0,1,2 write 0x1, hart 3 writes 0xB (code 5) -> tests_failed_o=1, exit_code_o=5, fail_hart_o=3, tests_passed_o stays 0.
- NUM_HARTS=2: hart 0 writes 0x1 twice, then 0x3 -> no fail (first write wins); DONE_MASK reads 0x1; hart 1 writes 0x1 -> pass.
- TIMEOUT_CYCLES=100: kick at cycle 90, then idle -> timeout_o and tests_failed_o rise exactly 100 cycles after the kick edge; a later EXIT write changes nothing.
- Preload counter near 0xFFFF_FFFF (run 2^32-2 cycles, or force): read LO then HI across the carry -> HI snapshot is consistent with LO; counter wraps the low word correctly.
- Assert rst_i in PASS state with a read in flight -> rvalid given the next cycle, then all outputs 0 and state RUN; unmapped read of 0x80 returns 0.

Source files
------------

// File: rtl/tb_test_status_ctrl.sv
// End-of-test controller for the core bench: per-hart exit registers, a
// pass/fail/timeout state machine, a watchdog and a 64-bit cycle counter,
// all reachable over the simple req/gnt/rvalid data bus.
module tb_test_status_ctrl #(
  parameter int NUM_HARTS      = 1,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  tests_passed_o,
  output logic                  tests_failed_o,
  output logic                  timeout_o,
  output logic [30:0]           exit_code_o,
  output logic [3:0]            fail_hart_o,
  output logic [1:0]            state_o
);

  // Bus handshake: a request is granted in the cycle it is raised (gnt = req,
  // never stalls); each granted request, read or write, gets exactly one
  // rvalid pulse in the following cycle, with rdata meaningful only while
  // rvalid is high (0 otherwise). Back-to-back requests are accepted.

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam logic [15:0] HART_MASK = 16'((32'd1 << NUM_HARTS) - 32'd1);

  localparam logic [31:0] W_CYCLE_LO  = 32'd16;
  localparam logic [31:0] W_CYCLE_HI  = 32'd17;
  localparam logic [31:0] W_DONE_MASK = 32'd18;
  localparam logic [31:0] W_WDOG_KICK = 32'd19;

  state_e      state_q, state_d;
  logic [15:0] done_q;
  logic [31:0] wdog_q;
  logic [63:0] cycle_q;
  logic [31:0] snap_hi_q;
  logic [30:0] code_q;
  logic [3:0]  hart_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic [31:0] word_idx;
  logic [3:0]  hart_sel;
  logic [15:0] hart_onehot;
  logic        bus_wr, bus_rd;
  logic        exit_accept, code_nz, kick, wdog_clear, all_done_next;
  logic [31:0] read_mux;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^data_addr_i[1:0];

  // Address decode and the qualified events that drive the state machine.
  always_comb begin
    word_idx      = 32'(data_addr_i[ADDR_WIDTH-1:2]);
    hart_sel      = word_idx[3:0];
    hart_onehot   = 16'd1 << hart_sel;
    bus_wr        = data_req_i & data_we_i;
    bus_rd        = data_req_i & ~data_we_i;
    code_nz       = |data_wdata_i[31:1];
    // Only the first done write per in-range hart counts, and only in RUN.
    exit_accept   = bus_wr && (word_idx < 32'(NUM_HARTS)) && data_wdata_i[0]
                    && !done_q[hart_sel] && (state_q == ST_RUN);
    kick          = bus_wr && (word_idx == W_WDOG_KICK);
    wdog_clear    = kick || exit_accept;
    all_done_next = &(done_q | hart_onehot | ~HART_MASK);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state: a failing exit beats completion, and either beats the watchdog.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (exit_accept && code_nz)
        state_d = ST_FAIL;
      else if (exit_accept && all_done_next)
        state_d = ST_PASS;
      else if ((TIMEOUT_CYCLES != 0) && !wdog_clear &&
               (wdog_q + 32'd1 == 32'(TIMEOUT_CYCLES)))
        state_d = ST_TIMEOUT;
    end
  end

  // Verdict outputs decode directly from the registered state.
  always_comb begin
    tests_passed_o = (state_q == ST_PASS);
    tests_failed_o = (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
    timeout_o      = (state_q == ST_TIMEOUT);
    state_o        = state_q;
  end

  // Counters, done mask, CYCLE_HI snapshot and the failing hart's code.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q    <= '0;
      wdog_q    <= '0;
      cycle_q   <= '0;
      snap_hi_q <= '0;
      code_q    <= '0;
      hart_q    <= '0;
    end else begin
      if (state_q == ST_RUN) begin
        cycle_q <= cycle_q + 64'd1;
        wdog_q  <= wdog_clear ? 32'd0 : wdog_q + 32'd1;
      end
      if (exit_accept) done_q <= done_q | hart_onehot;
      if (exit_accept && code_nz) begin
        code_q <= data_wdata_i[31:1];
        hart_q <= hart_sel;
      end
      if (bus_rd && (word_idx == W_CYCLE_LO)) snap_hi_q <= cycle_q[63:32];
    end
  end

  // Read data is taken from register values before the accepting edge.
  always_comb begin
    read_mux = '0;
    if (word_idx == W_CYCLE_LO)       read_mux = cycle_q[31:0];
    else if (word_idx == W_CYCLE_HI)  read_mux = snap_hi_q;
    else if (word_idx == W_DONE_MASK) read_mux = {16'd0, done_q & HART_MASK};
  end

  // Response stage: every request, even one arriving with reset, is answered.
  always_ff @(posedge clk_i) begin
    rvalid_q <= data_req_i;
    rdata_q  <= bus_rd ? read_mux : 32'd0;
  end

  assign data_gnt_o    = data_req_i;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rvalid_q ? rdata_q : 32'd0;
  assign exit_code_o   = code_q;
  assign fail_hart_o   = hart_q;

endmodule

// File: tb/tb_tb_test_status_ctrl.sv
// Bench for tb_test_status_ctrl (4 harts, 100-cycle watchdog): directed bus
// vectors push their expected response into a queue, a negedge monitor pops
// and compares; verdict outputs are checked against hand-computed constants.
module tb_tb_test_status_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        gnt, rvalid, passed, failed, tmo;
  logic [31:0] rdata;
  logic [30:0] exit_code;
  logic [3:0]  fail_hart;
  logic [1:0]  state;

  tb_test_status_ctrl #(
    .NUM_HARTS(4), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .data_req_i(req), .data_we_i(we), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_gnt_o(gnt), .data_rvalid_o(rvalid), .data_rdata_o(rdata),
    .tests_passed_o(passed), .tests_failed_o(failed), .timeout_o(tmo),
    .exit_code_o(exit_code), .fail_hart_o(fail_hart), .state_o(state)
  );

  // Edges since the last reset edge; equals the cycle counter while in RUN.
  int unsigned edges = 0;
  always @(posedge clk) begin
    if (rst_i) edges <= 0;
    else       edges <= edges + 1;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int n_cmp = 0;
  int n_fail = 0;

  always @(negedge clk) begin
    if (rvalid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: rvalid with no pending request, rdata=%h", rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rdata !== mon_exp) begin
          n_fail++;
          $display("FAIL rdata: got %h expected %h", rdata, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp);
    req = 1'b1; we = w; addr = a; wdata = d;
    exp_q.push_back(exp);
    #1 chk("gnt", {31'd0, gnt}, 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    issue(1'b1, a, d, 32'd0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp);
    issue(1'b0, a, 32'd0, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  int unsigned frozen;

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_passed", {31'd0, passed}, 32'd0);
    chk("rst_failed", {31'd0, failed}, 32'd0);
    chk("rst_timeout", {31'd0, tmo}, 32'd0);
    chk("rst_exit_code", {1'b0, exit_code}, 32'd0);
    chk("rst_fail_hart", {28'd0, fail_hart}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);

    // Harts 0..2 pass, hart 3 exits with code 5.
    wr(8'h00, 32'h1); wr(8'h04, 32'h1); wr(8'h08, 32'h1);
    @(negedge clk);
    chk("a_failed_pre", {31'd0, failed}, 32'd0);
    chk("a_passed_pre", {31'd0, passed}, 32'd0);
    wr(8'h0C, 32'hB);
    @(negedge clk);
    chk("a_failed", {31'd0, failed}, 32'd1);
    chk("a_exit_code", {1'b0, exit_code}, 32'd5);
    chk("a_fail_hart", {28'd0, fail_hart}, 32'd3);
    chk("a_passed", {31'd0, passed}, 32'd0);
    chk("a_timeout", {31'd0, tmo}, 32'd0);
    chk("a_state", {30'd0, state}, 32'd2);
    rd(8'h48, 32'hF);

    // First done write wins; out-of-range and done=0 writes are ignored.
    do_reset();
    wr(8'h00, 32'h1); wr(8'h00, 32'h1); wr(8'h00, 32'h3);
    @(negedge clk);
    chk("b_no_fail", {31'd0, failed}, 32'd0);
    rd(8'h48, 32'h1);
    wr(8'h14, 32'h1);
    wr(8'h04, 32'h0);
    rd(8'h48, 32'h1);
    rd(8'h40, edges);
    rd(8'h44, 32'd0);
    wr(8'h04, 32'h1); wr(8'h08, 32'h1);
    @(negedge clk);
    chk("b_passed_pre", {31'd0, passed}, 32'd0);
    wr(8'h0C, 32'h1);
    @(negedge clk);
    chk("b_passed", {31'd0, passed}, 32'd1);
    chk("b_failed", {31'd0, failed}, 32'd0);
    chk("b_exit_code", {1'b0, exit_code}, 32'd0);
    chk("b_state", {30'd0, state}, 32'd1);
    frozen = edges;
    idle(5);
    rd(8'h40, frozen);
    rd(8'h48, 32'hF);

    // Watchdog: kick, then exactly 100 idle edges to timeout.
    do_reset();
    idle(20);
    wr(8'h4C, 32'h1234_5678);
    repeat (99) @(posedge clk);
    @(negedge clk);
    chk("c_timeout_early", {31'd0, tmo}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("c_timeout", {31'd0, tmo}, 32'd1);
    chk("c_failed", {31'd0, failed}, 32'd1);
    chk("c_passed", {31'd0, passed}, 32'd0);
    wr(8'h00, 32'hB);
    @(negedge clk);
    chk("c_exit_code", {1'b0, exit_code}, 32'd0);
    chk("c_fail_hart", {28'd0, fail_hart}, 32'd0);
    chk("c_state", {30'd0, state}, 32'd3);
    rd(8'h48, 32'd0);

    // Carry from CYCLE_LO into CYCLE_HI with a consistent snapshot.
    do_reset();
    @(negedge clk);
    force dut.cycle_q = 64'h0000_0000_ffff_fffe;
    #1 release dut.cycle_q;
    @(posedge clk);
    #1;
    rd(8'h40, 32'hffff_ffff);
    rd(8'h44, 32'h0);
    rd(8'h40, 32'h0000_0001);
    rd(8'h44, 32'h1);

    // Reach PASS, then reset with an unmapped read in flight.
    wr(8'h00, 32'h1); wr(8'h04, 32'h1); wr(8'h08, 32'h1); wr(8'h0C, 32'h1);
    @(negedge clk);
    chk("e_passed", {31'd0, passed}, 32'd1);
    req = 1'b1; we = 1'b0; addr = 8'h80; rst_i = 1'b1;
    exp_q.push_back(32'd0);
    @(posedge clk);
    #1;
    req = 1'b0; addr = '0; rst_i = 1'b0;
    @(negedge clk);
    chk("e_rvalid", {31'd0, rvalid}, 32'd1);
    chk("e_passed_clr", {31'd0, passed}, 32'd0);
    chk("e_failed_clr", {31'd0, failed}, 32'd0);
    chk("e_state", {30'd0, state}, 32'd0);
    rd(8'h48, 32'd0);
    rd(8'h80, 32'd0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
